// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Build option: HAZARD_WB_BYPASS_EN selects WB->ID bypass over a WB stall.
package pipe_pkg;

  localparam int REG_AW = 5;
  localparam int SEL_W  = 2;

  localparam logic [SEL_W-1:0] FWD_RF = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              load;
    logic              valid;
  } id_info_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] top;
    top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard bundle between the pipeline and its hazard controller.
// byp_a/byp_b only assert when built with HAZARD_WB_BYPASS_EN.
interface pipe_hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_wen;
  logic              id_load;
  logic              flush;
  logic              ext_stall;

  logic              pc_en;
  logic              id_ex_bubble;
  logic              if_id_flush;
  logic [SEL_W-1:0]  fwd_a;
  logic [SEL_W-1:0]  fwd_b;
  logic              byp_a;
  logic              byp_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_use_rs, id_use_rt,
    output id_rd, id_wen, id_load,
    output flush, ext_stall,
    input  pc_en, id_ex_bubble, if_id_flush,
    input  fwd_a, fwd_b, byp_a, byp_b,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_use_rs, id_use_rt,
    input  id_rd, id_wen, id_load,
    input  flush, ext_stall,
    output pc_en, id_ex_bubble, if_id_flush,
    output fwd_a, fwd_b, byp_a, byp_b,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_match.sv
// Per-operand DEPTH-way producer compare; the youngest producer wins.
// sel is the winning stage index, not the forward select.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  id_info_t [DEPTH-1:0] trk,
  input  logic [REG_AW-1:0]    src,
  input  logic                 use_src,
  input  logic                 id_valid,
  output logic                 hit,
  output logic [SEL_W-1:0]     sel,
  output logic                 is_load
);

  logic live;

  assign live = id_valid && use_src && (src != '0);

  always_comb begin
    hit     = 1'b0;
    sel     = '0;
    is_load = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (live && trk[j].valid && trk[j].wen &&
          trk[j].rd == src) begin
        hit     = 1'b1;
        sel     = SEL_W'(j);
        is_load = trk[j].load;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: dest-reg shadowing, fwd selects, stalls, flushes.
// Build option: HAZARD_WB_BYPASS_EN turns the WB-only stall into a bypass.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input logic               clock,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  id_info_t [DEPTH-1:0] trk;

  logic             hit_a, hit_b;
  logic             ld_a, ld_b;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             wb_a, wb_b;
  logic             lu_stall;
  logic             hz_stall;
  logic             kill;
  logic             pc_en;

  hazard_match #(.DEPTH(DEPTH)) u_match_a (
    .trk      (trk),
    .src      (hz.id_rs),
    .use_src  (hz.id_use_rs),
    .id_valid (hz.id_valid),
    .hit      (hit_a),
    .sel      (sel_a),
    .is_load  (ld_a)
  );

  hazard_match #(.DEPTH(DEPTH)) u_match_b (
    .trk      (trk),
    .src      (hz.id_rt),
    .use_src  (hz.id_use_rt),
    .id_valid (hz.id_valid),
    .hit      (hit_b),
    .sel      (sel_b),
    .is_load  (ld_b)
  );

  assign wb_a = hit_a && (sel_a == SEL_W'(DEPTH - 1));
  assign wb_b = hit_b && (sel_b == SEL_W'(DEPTH - 1));

  assign lu_stall = (hit_a && ld_a && sel_a == '0) ||
                    (hit_b && ld_b && sel_b == '0);

`ifdef HAZARD_WB_BYPASS_EN
  assign hz.byp_a  = wb_a;
  assign hz.byp_b  = wb_b;
  assign hz_stall  = lu_stall;
`else
  assign hz.byp_a  = 1'b0;
  assign hz.byp_b  = 1'b0;
  assign hz_stall  = lu_stall || wb_a || wb_b;
`endif

  // flush kills the ID victim, so it overrides any hazard it raised
  always_comb begin
    pc_en           = 1'b1;
    hz.id_ex_bubble = 1'b0;
    hz.if_id_flush  = 1'b0;
    if (hz.ext_stall) begin
      pc_en = 1'b0;
    end else if (hz.flush) begin
      hz.if_id_flush = 1'b1;
    end else if (hz_stall) begin
      pc_en           = 1'b0;
      hz.id_ex_bubble = 1'b1;
    end
  end

  assign hz.pc_en = pc_en;
  assign kill     = hz_stall || hz.flush || !hz.id_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trk          <= '0;
      hz.fwd_a     <= FWD_RF;
      hz.fwd_b     <= FWD_RF;
      hz.stall_cnt <= '0;
      hz.flush_cnt <= '0;
    end else begin
      if (!pc_en)
        hz.stall_cnt <= CNT_W'(sat_inc(32'(hz.stall_cnt), CNT_W));
      if (hz.flush && !hz.ext_stall)
        hz.flush_cnt <= CNT_W'(sat_inc(32'(hz.flush_cnt), CNT_W));
      if (!hz.ext_stall) begin
        for (int j = 1; j < DEPTH; j++)
          trk[j] <= trk[j-1];
        if (kill)
          trk[0] <= '0;
        else
          trk[0] <= '{rd: hz.id_rd, wen: hz.id_wen,
                      load: hz.id_load, valid: 1'b1};
        if (hz_stall || hz.flush) begin
          hz.fwd_a <= FWD_RF;
          hz.fwd_b <= FWD_RF;
        end else begin
          hz.fwd_a <= (hit_a && !wb_a) ? sel_a + SEL_W'(1) : FWD_RF;
          hz.fwd_b <= (hit_b && !wb_b) ? sel_b + SEL_W'(1) : FWD_RF;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Random-stimulus bench for pipe_hazard_ctrl against an in-flight instruction model.
// Honours HAZARD_WB_BYPASS_EN the same way the design does.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int DEPTH = 3;
  localparam int CNT_W = 5;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clock;
  logic reset;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) intf ();

  pipe_hazard_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (intf.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk;
  int n_pass;

  // in-flight instructions after ID: index 0 = EX
  int m_v  [DEPTH];
  int m_w  [DEPTH];
  int m_l  [DEPTH];
  int m_rd [DEPTH];
  int m_fa, m_fb, m_sc, m_fc;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, got, exp, $time);
  endtask

  function automatic int find(input int src, input bit use_it);
    if (!(intf.id_valid && use_it && src != 0)) return -1;
    for (int j = 0; j < DEPTH; j++)
      if (m_v[j] != 0 && m_w[j] != 0 && m_rd[j] == src) return j;
    return -1;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < DEPTH; j++) begin
      m_v[j] = 0; m_w[j] = 0; m_l[j] = 0; m_rd[j] = 0;
    end
    m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic reset_dut();
    @(negedge clock);
    intf.ext_stall = 1'b0;
    intf.flush     = 1'b0;
    intf.id_valid  = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    chk("rst_fwd_a", int'(intf.fwd_a), 0);
    chk("rst_fwd_b", int'(intf.fwd_b), 0);
    chk("rst_stall_cnt", int'(intf.stall_cnt), 0);
    chk("rst_flush_cnt", int'(intf.flush_cnt), 0);
    chk("rst_pc_en", int'(intf.pc_en), 1);
    chk("rst_bubble", int'(intf.id_ex_bubble), 0);
    chk("rst_if_id_flush", int'(intf.if_id_flush), 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run(input int cycles, input int p_ext, input int p_fl);
    int  pa, pb;
    bit  ext, fl, stall, lu, wb_a, wb_b;
    int  e_pc, e_bub, e_iff, e_ba, e_bb;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      intf.id_valid  = ($urandom_range(99) < 85);
      intf.id_rs     = REG_AW'($urandom_range(3));
      intf.id_rt     = REG_AW'($urandom_range(3));
      intf.id_use_rs = ($urandom_range(99) < 75);
      intf.id_use_rt = ($urandom_range(99) < 60);
      intf.id_rd     = REG_AW'($urandom_range(3));
      intf.id_wen    = ($urandom_range(99) < 75);
      intf.id_load   = ($urandom_range(99) < 35);
      intf.flush     = ($urandom_range(99) < p_fl);
      intf.ext_stall = ($urandom_range(99) < p_ext);
      #1;
      ext  = intf.ext_stall;
      fl   = intf.flush;
      pa   = find(int'(intf.id_rs), intf.id_use_rs);
      pb   = find(int'(intf.id_rt), intf.id_use_rt);
      lu   = (pa == 0 && m_l[0] != 0) || (pb == 0 && m_l[0] != 0);
      wb_a = (pa == DEPTH - 1);
      wb_b = (pb == DEPTH - 1);
`ifdef HAZARD_WB_BYPASS_EN
      stall = lu;
      e_ba  = int'(wb_a);
      e_bb  = int'(wb_b);
`else
      stall = lu || wb_a || wb_b;
      e_ba  = 0;
      e_bb  = 0;
`endif
      e_pc  = (ext || (!fl && stall)) ? 0 : 1;
      e_bub = (!ext && !fl && stall) ? 1 : 0;
      e_iff = (!ext && fl) ? 1 : 0;
      chk("pc_en", int'(intf.pc_en), e_pc);
      chk("id_ex_bubble", int'(intf.id_ex_bubble), e_bub);
      chk("if_id_flush", int'(intf.if_id_flush), e_iff);
      chk("byp_a", int'(intf.byp_a), e_ba);
      chk("byp_b", int'(intf.byp_b), e_bb);
      chk("fwd_a", int'(intf.fwd_a), m_fa);
      chk("fwd_b", int'(intf.fwd_b), m_fb);
      chk("stall_cnt", int'(intf.stall_cnt), m_sc);
      chk("flush_cnt", int'(intf.flush_cnt), m_fc);
      @(posedge clock);
      if (e_pc == 0 && m_sc < MAXC) m_sc++;
      if (e_iff == 1 && m_fc < MAXC) m_fc++;
      if (!ext) begin
        for (int j = DEPTH - 1; j >= 1; j--) begin
          m_v[j] = m_v[j-1]; m_w[j] = m_w[j-1];
          m_l[j] = m_l[j-1]; m_rd[j] = m_rd[j-1];
        end
        if (stall || fl || !intf.id_valid) begin
          m_v[0] = 0; m_w[0] = 0; m_l[0] = 0; m_rd[0] = 0;
        end else begin
          m_v[0]  = 1;
          m_w[0]  = int'(intf.id_wen);
          m_l[0]  = int'(intf.id_load);
          m_rd[0] = int'(intf.id_rd);
        end
        if (stall || fl) begin
          m_fa = 0; m_fb = 0;
        end else begin
          m_fa = (pa >= 0 && pa < DEPTH - 1) ? pa + 1 : 0;
          m_fb = (pb >= 0 && pb < DEPTH - 1) ? pb + 1 : 0;
        end
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b0;
    intf.id_valid  = 1'b0;
    intf.id_rs     = '0;
    intf.id_rt     = '0;
    intf.id_use_rs = 1'b0;
    intf.id_use_rt = 1'b0;
    intf.id_rd     = '0;
    intf.id_wen    = 1'b0;
    intf.id_load   = 1'b0;
    intf.flush     = 1'b0;
    intf.ext_stall = 1'b0;
    model_clear();
    reset_dut();
    run(300, 0, 0);
    reset_dut();
    run(300, 15, 10);
    run(20, 100, 30);
    reset_dut();
    run(60, 40, 0);
    reset_dut();
    run(80, 5, 60);
    run(20, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
